bcd_display_conv: RTL and testbench

//  Sequential signed-binary to 4-digit BCD converter using the shift-add-3 (double dabble) method.

---
 rtl/calc_pkg.sv | 25 ++
 rtl/bcd_display_conv_if.sv | 25 ++
 rtl/bcd_add3.sv | 8 +
 rtl/bcd_display_conv.sv | 147 ++++++++++++++
 tb/tb_bcd_display_conv.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared calculator constants and the BCD converter's state encoding.
// Imported by the ALU overflow check and the display converter.
package calc_pkg;

  localparam int DIGITS  = 4;
  localparam int MAX_MAG = 9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } conv_state_e;

  // True when every nibble of a packed BCD word is a legal decimal digit.
  function automatic logic digits_ok(input logic [4*DIGITS-1:0] b);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_display_conv_if.sv
// Handshake and result bundle between the ALU side (master) and the
// BCD display converter (slave).
interface bcd_display_conv_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  overflow_in;
  logic                  busy;
  logic                  done;
  logic                  neg;
  logic [4*DIGITS-1:0]   bcd;
  logic                  err;

  modport master (
    output start, value, overflow_in,
    input  busy, done, neg, bcd, err
  );

  modport slave (
    input  start, value, overflow_in,
    output busy, done, neg, bcd, err
  );
endinterface

// File: rtl/bcd_add3.sv
// One double-dabble correction cell: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bcd_display_conv.sv
// Sequential signed-binary to BCD converter (shift-add-3) feeding the
// seven-segment driver; one conversion at a time behind a start/busy/done handshake.
module bcd_display_conv
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  bcd_display_conv_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH:0]   MAX_MAG_W = (WIDTH + 1)'(MAX_MAG);

  conv_state_e        state_q, state_d;
  logic [WIDTH-1:0]   value_q, value_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic               ovf_q, ovf_d;
  logic               neg_pend_q, neg_pend_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               neg_q, neg_d;
  logic               err_q, err_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;

  logic [BCD_W-1:0]   corr;
  logic [BCD_W-1:0]   shifted;
  logic [WIDTH:0]     sext;
  logic [WIDTH:0]     mag_full;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch_q[4*g +: 4]),
      .dout (corr[4*g +: 4])
    );
  end

  // One extra bit keeps the magnitude of the most negative input representable.
  assign sext     = {value_q[WIDTH-1], value_q};
  assign mag_full = value_q[WIDTH-1] ? -sext : sext;
  assign shifted  = {corr[BCD_W-2:0], mag_q[WIDTH-1]};

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    value_d    = value_q;
    mag_d      = mag_q;
    ovf_d      = ovf_q;
    neg_pend_d = neg_pend_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    err_d      = err_q;
    bcd_d      = bcd_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          value_d = bus.value;
          ovf_d   = bus.overflow_in;
          state_d = LOAD;
        end
      end
      LOAD: begin
        neg_pend_d = value_q[WIDTH-1] && (value_q != '0);
        if (ovf_q || (mag_full > MAX_MAG_W)) begin
          // Undisplayable: publish the error on entry to DONE, skipping the shifts.
          bcd_d   = '0;
          neg_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          mag_d     = mag_full[WIDTH-1:0];
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shifted;
        mag_d     = mag_q << 1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          bcd_d   = shifted;
          neg_d   = neg_pend_q;
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status flags are registered so they line up with the state they describe.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its _d regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      value_q    <= '0;
      mag_q      <= '0;
      ovf_q      <= 1'b0;
      neg_pend_q <= 1'b0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      neg_q      <= 1'b0;
      err_q      <= 1'b0;
      bcd_q      <= '0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      mag_q      <= mag_d;
      ovf_q      <= ovf_d;
      neg_pend_q <= neg_pend_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      neg_q      <= neg_d;
      err_q      <= err_d;
      bcd_q      <= bcd_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.neg  = neg_q;
  assign bus.err  = err_q;
  assign bus.bcd  = bcd_q;

  a_digits_legal: assert property (
    @(posedge clk) disable iff (reset) (state_q == SHIFT) |-> digits_ok(shifted)
  );

endmodule

// File: tb/tb_bcd_display_conv.sv
// Directed plus randomized bench for bcd_display_conv; expected results come
// from a decimal-arithmetic model of the signed value.
module tb_bcd_display_conv;

  typedef struct packed {
    logic        neg;
    logic [15:0] bcd;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bcd_display_conv_if #(.WIDTH(16), .DIGITS(4)) bus ();

  bcd_display_conv #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain decimal arithmetic on the signed value.
  function automatic exp_t model(input logic [15:0] v, input logic ovf);
    exp_t e;
    int   s;
    int   m;
    s = $signed(v);
    m = (s < 0) ? -s : s;
    if (ovf || m > 9999) begin
      e = '{neg: 1'b0, bcd: 16'h0000, err: 1'b1};
    end else begin
      e.neg = (s < 0);
      e.bcd = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
      e.err = 1'b0;
    end
    return e;
  endfunction

  // One conversion; optionally pokes a second start at cycle poke_at (0 = none).
  task automatic run(input logic [15:0] v, input logic ovf, input string tag,
                     input int poke_at, input logic [15:0] poke_v);
    exp_t        e;
    logic [15:0] prev_bcd;
    logic        prev_neg, prev_err, seen;
    int          n, busy_bad, hold_bad, lat;
    e = model(v, ovf);
    lat = e.err ? 2 : 18;
    @(negedge clk);
    prev_bcd = bus.bcd; prev_neg = bus.neg; prev_err = bus.err;
    bus.start = 1'b1; bus.value = v; bus.overflow_in = ovf;
    @(negedge clk);
    bus.start = 1'b0; bus.value = 16'($urandom); bus.overflow_in = 1'b0;
    n = 1; seen = 1'b0; busy_bad = 0; hold_bad = 0;
    while (!seen && n <= 40) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (!bus.busy) busy_bad++;
        if (bus.bcd !== prev_bcd || bus.neg !== prev_neg || bus.err !== prev_err) hold_bad++;
        if (n == poke_at) begin
          bus.start = 1'b1; bus.value = poke_v;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        n++;
      end
    end
    bus.start = 1'b0;
    chk({tag, " done_seen"}, 32'(seen), 32'(1));
    chk({tag, " latency"}, 32'(n), 32'(lat));
    chk({tag, " busy_during"}, 32'(busy_bad), 32'(0));
    chk({tag, " held_until_done"}, 32'(hold_bad), 32'(0));
    chk({tag, " busy_at_done"}, 32'(bus.busy), 32'(1));
    chk({tag, " bcd"}, 32'(bus.bcd), 32'(e.bcd));
    chk({tag, " neg"}, 32'(bus.neg), 32'(e.neg));
    chk({tag, " err"}, 32'(bus.err), 32'(e.err));
    @(negedge clk);
    chk({tag, " done_pulse"}, 32'(bus.done), 32'(0));
    chk({tag, " idle_busy"}, 32'(bus.busy), 32'(0));
  endtask

  initial begin
    int done_in_reset;
    logic [15:0] rv;
    logic        rovf;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.value = '0;
    bus.overflow_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(bus.busy), 32'(0));
    chk("reset done", 32'(bus.done), 32'(0));
    chk("reset neg", 32'(bus.neg), 32'(0));
    chk("reset bcd", 32'(bus.bcd), 32'(0));
    chk("reset err", 32'(bus.err), 32'(0));
    reset = 1'b0;

    run(16'd1234, 1'b0, "t1_1234", 0, '0);
    run(16'(-9999), 1'b0, "t2_m9999", 0, '0);
    run(16'd0, 1'b0, "t2_zero", 0, '0);
    run(16'd10000, 1'b0, "t3_10000", 0, '0);
    run(16'h8000, 1'b0, "t3_m32768", 0, '0);
    run(16'd9999, 1'b0, "edge_9999", 0, '0);
    run(16'd5, 1'b1, "t4_ovf", 0, '0);
    run(16'd42, 1'b0, "t4_42", 0, '0);
    run(16'd1234, 1'b0, "t5_ignore", 5, 16'd777);

    // Reset mid-conversion: outputs clear without a clock edge, no done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.value = 16'd1234;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6 busy_async", 32'(bus.busy), 32'(0));
    chk("t6 bcd_async", 32'(bus.bcd), 32'(0));
    chk("t6 neg_async", 32'(bus.neg), 32'(0));
    chk("t6 err_async", 32'(bus.err), 32'(0));
    done_in_reset = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) done_in_reset++;
    end
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_in_reset++;
    end
    chk("t6 no_done_after_abort", 32'(done_in_reset), 32'(0));
    run(16'd56, 1'b0, "t6_56", 0, '0);

    for (int i = 0; i < 30; i++) begin
      rv   = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                         : 16'($signed($urandom_range(0, 24000)) - 12000);
      rovf = ($urandom_range(0, 7) == 0);
      run(rv, rovf, $sformatf("rand%0d_%0d", i, $signed(rv)), 0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
